// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle wide adder/subtractor: one 4-bit carry-lookahead slice
// reused over WIDTH/4 chunks, LSB chunk first, with valid/ready on both sides.
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / 4;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [3:0]       ac;
  logic [3:0]       bc;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [3:0]       c;
  logic             gg;
  logic             pp;
  logic             c4;
  logic [3:0]       s;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;

  always_comb begin
    ac = '0;
    bc = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        ac = a_q[4*k +: 4];
        bc = b_q[4*k +: 4];
      end
    end
  end

  assign p = ac ^ bc;
  assign g = ac & bc;

  // Full lookahead from the registered chunk carry-in
  assign c[0] = carry_q;
  assign c[1] = g[0] | (p[0] & carry_q);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & carry_q);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
  assign gg = g[3] | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign pp = &p;
  assign c4 = gg | (pp & carry_q);
  assign s  = p ^ c;

  always_comb begin
    sum_nxt = sum;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        sum_nxt[4*k +: 4] = s;
      end
    end
  end

  assign last = (cnt == CW'(NCHUNK - 1));

  assign in_ready  = (state == S_IDLE) & ~rst;
  assign busy      = (state == S_RUN);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            sum     <= '0;
            cnt     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          sum     <= sum_nxt;
          carry_q <= c4;
          cnt     <= cnt + CW'(1);
          if (last) begin
            cout  <= c4;
            ovf   <= c[3] ^ c4;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
